// File: rtl/display_controller.sv
`timescale 1ns/1ps
// display_controller: shares the 8-digit display between four 32-bit sources
// and delivers hex digits or sequentially converted BCD digits to the driver.
module display_controller #(
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] src_data,
  input  logic [3:0]   src_valid,
  input  logic         mode_auto,
  input  logic [1:0]   manual_sel,
  input  logic         dec_en,
  output logic [31:0]  disp_data,
  output logic [1:0]   disp_src,
  output logic         disp_dec,
  output logic         ovf,
  output logic         busy,
  output logic         update
);

  localparam int unsigned DW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST   = DW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_CONVERT = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        mode_q, dec_prev_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic        pending_q, pending_d;
  logic [31:0] value_q, value_d;
  logic [1:0]  cap_src_q, cap_src_d;
  logic        cap_dec_q, cap_dec_d;
  logic [39:0] acc_q, acc_d, acc_adj_s;
  logic [4:0]  step_q, step_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic [1:0]  disp_src_q, disp_src_d;
  logic        disp_dec_q, disp_dec_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        update_q, update_d;
  logic        dwell_exp_s, refresh_exp_s, event_s;

  // Round-robin search order sel+1, sel+2, sel+3, sel; holds when nothing is valid.
  function automatic logic [1:0] next_valid(input logic [1:0] cur, input logic [3:0] valid);
    logic [1:0] res;
    logic [1:0] cand;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      res  = valid[cand] ? cand : res;
    end
    return res;
  endfunction

  function automatic logic [39:0] bcd_adjust(input logic [39:0] acc);
    logic [39:0] res;
    res = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[4*i +: 4] >= 4'd5) res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      else                       res[4*i +: 4] = acc[4*i +: 4];
    end
    return res;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) state_d = S_CAPTURE;
        else           state_d = S_IDLE;
      end
      S_CAPTURE: begin
        if (dec_en) state_d = S_CONVERT;
        else        state_d = S_COMMIT;
      end
      S_CONVERT: begin
        if (step_q == 5'd31) state_d = S_COMMIT;
        else                 state_d = S_CONVERT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs, registered so the driver sees a clean image only at commit
  always_comb begin
    busy_d      = (state_d == S_CAPTURE) || (state_d == S_CONVERT);
    update_d    = 1'b0;
    disp_data_d = disp_data_q;
    disp_src_d  = disp_src_q;
    disp_dec_d  = disp_dec_q;
    ovf_d       = ovf_q;
    if (state_q == S_COMMIT) begin
      update_d   = 1'b1;
      disp_src_d = cap_src_q;
      disp_dec_d = cap_dec_q;
      if (cap_dec_q) begin
        disp_data_d = acc_q[31:0];
        ovf_d       = (acc_q[39:32] != 8'd0);
      end else begin
        disp_data_d = value_q;
        ovf_d       = 1'b0;
      end
    end else begin
      update_d = 1'b0;
    end
  end

  // Selection, dwell/refresh timers, pending flag and conversion datapath
  always_comb begin
    dwell_exp_s   = mode_auto && (dwell_q == DWELL_LAST);
    refresh_exp_s = (refresh_q == REFRESH_LAST);
    if (!mode_auto || (mode_auto != mode_q) || dwell_exp_s) dwell_d = '0;
    else                                                    dwell_d = dwell_q + DW'(1);
    if (refresh_exp_s) refresh_d = '0;
    else               refresh_d = refresh_q + RW'(1);
    if (!mode_auto)       sel_d = manual_sel;
    else if (dwell_exp_s) sel_d = next_valid(sel_q, src_valid);
    else                  sel_d = sel_q;
    event_s = (sel_d != sel_q) || (dec_en != dec_prev_q) || refresh_exp_s;
    // Anything coinciding with entry to CAPTURE is already seen by the capture itself.
    if (state_q == S_IDLE && pending_q) pending_d = 1'b0;
    else if (event_s)                   pending_d = 1'b1;
    else                                pending_d = pending_q;

    acc_adj_s = bcd_adjust(acc_q);
    value_d   = value_q;
    cap_src_d = cap_src_q;
    cap_dec_d = cap_dec_q;
    acc_d     = acc_q;
    step_d    = step_q;
    case (state_q)
      S_CAPTURE: begin
        value_d   = src_data[{sel_q, 5'd0} +: 32];
        cap_src_d = sel_q;
        cap_dec_d = dec_en;
        acc_d     = 40'd0;
        step_d    = 5'd0;
      end
      S_CONVERT: begin
        acc_d  = {acc_adj_s[38:0], value_q[5'd31 - step_q]};
        step_d = step_q + 5'd1;
      end
      default: begin
        acc_d  = acc_q;
        step_d = step_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= 2'd0;
      mode_q      <= 1'b0;
      dec_prev_q  <= 1'b0;
      dwell_q     <= '0;
      refresh_q   <= '0;
      pending_q   <= 1'b1;
      value_q     <= 32'd0;
      cap_src_q   <= 2'd0;
      cap_dec_q   <= 1'b0;
      acc_q       <= 40'd0;
      step_q      <= 5'd0;
      disp_data_q <= 32'd0;
      disp_src_q  <= 2'd0;
      disp_dec_q  <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      mode_q      <= mode_auto;
      dec_prev_q  <= dec_en;
      dwell_q     <= dwell_d;
      refresh_q   <= refresh_d;
      pending_q   <= pending_d;
      value_q     <= value_d;
      cap_src_q   <= cap_src_d;
      cap_dec_q   <= cap_dec_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      disp_data_q <= disp_data_d;
      disp_src_q  <= disp_src_d;
      disp_dec_q  <= disp_dec_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      update_q    <= update_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_src  = disp_src_q;
  assign disp_dec  = disp_dec_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign update    = update_q;

endmodule

// File: tb/tb_display_controller.sv
`timescale 1ns/1ps
// Bench for display_controller: directed scenarios plus randomized manual
// selection, checked against an arithmetic model of the displayed digits.
module tb_display_controller;

  localparam int HOLD = 8;
  localparam int REF  = 1000;

  logic         clk;
  logic         rst;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         mode_auto;
  logic [1:0]   manual_sel;
  logic         dec_en;
  logic [31:0]  disp_data;
  logic [1:0]   disp_src;
  logic         disp_dec;
  logic         ovf;
  logic         busy;
  logic         update;

  logic [31:0] src [4];
  int n_checks = 0;
  int n_errors = 0;

  always_comb src_data = {src[3], src[2], src[1], src[0]};

  display_controller #(.HOLD_CYCLES(HOLD), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .mode_auto(mode_auto), .manual_sel(manual_sel), .dec_en(dec_en),
    .disp_data(disp_data), .disp_src(disp_src), .disp_dec(disp_dec),
    .ovf(ovf), .busy(busy), .update(update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected display image: {ovf, digits}; decimal shows value mod 10^8.
  function automatic logic [32:0] ref_fmt(input logic [31:0] v, input logic dec);
    logic [32:0] r;
    logic [63:0] rem;
    r = 33'd0;
    if (!dec) begin
      r = {1'b0, v};
    end else begin
      rem = {32'd0, v} % 64'd100000000;
      for (int i = 0; i < 8; i++) begin
        r[4*i +: 4] = 4'(rem % 64'd10);
        rem = rem / 64'd10;
      end
      r[32] = (v >= 32'd100000000);
    end
    return r;
  endfunction

  function automatic logic [1:0] model_next(input logic [1:0] s, input logic [3:0] v);
    logic [1:0] r;
    int c;
    r = s;
    for (int k = 4; k >= 1; k--) begin
      c = (int'(s) + k) % 4;
      if (v[c]) r = 2'(c);
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_image(input string tag, input int idx, input logic dec);
    logic [32:0] r;
    r = ref_fmt(src[idx], dec);
    check_val({tag, "_data"}, 64'(disp_data), 64'(r[31:0]));
    check_val({tag, "_ovf"},  64'(ovf),       64'(r[32]));
    check_val({tag, "_src"},  64'(disp_src),  64'(idx));
    check_val({tag, "_dec"},  64'(disp_dec),  64'(dec));
  endtask

  task automatic expect_commit(input string tag, input int idx, input logic dec, input int busy_len);
    int t;
    int n;
    t = 0;
    while (busy !== 1'b1 && t < 60) begin step(); t++; end
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    if (busy_len >= 0) check_val({tag, "_busy_len"}, 64'(n), 64'(busy_len));
    check_val({tag, "_pre"}, 64'(update), 64'd0);
    step();
    check_val({tag, "_upd"}, 64'(update), 64'd1);
    check_image(tag, idx, dec);
    step();
    check_val({tag, "_pulse"}, 64'(update), 64'd0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int c;
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (update === 1'b1) c++;
    end
    check_val(tag, 64'(c), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"},   64'(disp_data), 64'd0);
    check_val({tag, "_src"},    64'(disp_src),  64'd0);
    check_val({tag, "_dec"},    64'(disp_dec),  64'd0);
    check_val({tag, "_ovf"},    64'(ovf),       64'd0);
    check_val({tag, "_busy"},   64'(busy),      64'd0);
    check_val({tag, "_update"}, 64'(update),    64'd0);
  endtask

  initial begin
    logic [1:0] exp_s, last_s, cur_sel, s;
    logic       cur_dec, d;
    int         cnt, last_t, t, nu;
    logic [32:0] r;

    rst = 1'b1; mode_auto = 1'b0; manual_sel = 2'd1; dec_en = 1'b0; src_valid = 4'b0000;
    for (int k = 0; k < 4; k++) src[k] = $urandom;
    src[1] = 32'h1234ABCD;

    // Reset values, then manual hex
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    expect_commit("hex", 1, 1'b0, 1);
    expect_quiet("hex_single", 40);

    // Decimal, zero and overflow
    src[0] = 32'd12345678; manual_sel = 2'd0; dec_en = 1'b1;
    expect_commit("dec", 0, 1'b1, 33);
    check_val("dec_lit", 64'(disp_data), 64'h12345678);
    expect_quiet("dec_single", 20);
    src[0] = 32'd0;
    do_reset();
    expect_commit("dec_zero", 0, 1'b1, 33);
    src[0] = 32'hFFFFFFFF;
    do_reset();
    expect_commit("ovf", 0, 1'b1, 33);
    check_val("ovf_lit", 64'(disp_data), 64'h94967295);

    // Selection change during conversion
    src[0] = $urandom; src[2] = $urandom; manual_sel = 2'd0; dec_en = 1'b1;
    do_reset();
    t = 0;
    while (busy !== 1'b1 && t < 60) begin step(); t++; end
    check_val("mid_busy", 64'(busy), 64'd1);
    repeat (10) step();
    manual_sel = 2'd2;
    expect_commit("mid1", 0, 1'b1, -1);
    expect_commit("mid2", 2, 1'b1, 33);
    expect_quiet("mid_two_only", 60);

    // Reset in the middle of a conversion
    src[0] = $urandom; src[1] = $urandom; manual_sel = 2'd0; dec_en = 1'b1;
    do_reset();
    expect_commit("rmc_pre", 0, 1'b1, 33);
    manual_sel = 2'd1;
    t = 0;
    while (busy !== 1'b1 && t < 60) begin step(); t++; end
    check_val("rmc_busy", 64'(busy), 64'd1);
    repeat (11) step();
    rst = 1'b1; manual_sel = 2'd0;
    step();
    check_reset_outputs("rmc_reset");
    rst = 1'b0;
    expect_commit("rmc_post", 0, 1'b1, 33);

    // Auto rotation over sources 1 and 3, then freeze with nothing valid
    for (int k = 0; k < 4; k++) src[k] = $urandom;
    mode_auto = 1'b1; src_valid = 4'b1010; dec_en = 1'b0;
    do_reset();
    exp_s = 2'd0; cnt = 0; last_t = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (update === 1'b1) begin
        check_image("auto", int'(exp_s), 1'b0);
        if (cnt >= 2) check_val("auto_gap", 64'(i - last_t), 64'(HOLD));
        last_t = i;
        cnt++;
        exp_s = model_next(exp_s, src_valid);
      end
    end
    check_val("auto_count", 64'(cnt >= 6), 64'd1);
    t = 0;
    while (update !== 1'b1 && t < 20) begin step(); t++; end
    check_val("auto_last_upd", 64'(update), 64'd1);
    check_image("auto_last", int'(exp_s), 1'b0);
    last_s = exp_s;
    src_valid = 4'b0000;
    expect_quiet("auto_frozen", 40);
    check_val("auto_frozen_src", 64'(disp_src), 64'(last_s));

    // Randomized manual selection and format changes
    mode_auto = 1'b0; manual_sel = 2'd0; dec_en = 1'b0;
    cur_sel = 2'd0; cur_dec = 1'b0;
    do_reset();
    expect_commit("rnd_init", 0, 1'b0, 1);
    for (int trial = 0; trial < 12; trial++) begin
      for (int k = 0; k < 4; k++) begin
        src[k] = $urandom;
        if ($urandom_range(0, 1) == 1) src[k] = 32'($urandom_range(0, 99999999));
      end
      s = 2'($urandom_range(0, 3));
      d = 1'($urandom_range(0, 1));
      if (s == cur_sel && d == cur_dec) s = s + 2'd1;
      manual_sel = s; dec_en = d; cur_sel = s; cur_dec = d;
      src_valid = 4'($urandom);
      nu = 0;
      for (int i = 0; i < 45; i++) begin
        step();
        if (update === 1'b1) begin
          nu++;
          check_image("rnd", int'(s), d);
        end
      end
      check_val("rnd_count", 64'(nu), 64'd1);
    end

    // Periodic refresh re-captures the same source
    manual_sel = 2'd3; dec_en = 1'b0; src[3] = $urandom;
    do_reset();
    expect_commit("ref_init", 3, 1'b0, 1);
    t = 0;
    while (update !== 1'b1 && t < 1100) begin step(); t++; end
    check_val("refresh_period", 64'(t + 1), 64'(REF));
    r = ref_fmt(src[3], 1'b0);
    check_val("refresh_data", 64'(disp_data), 64'(r[31:0]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
